// File: rtl/kalman_param_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package   : kalman_param_loader_pkg
// Purpose   : Shared definitions for the Kalman parameter loader. Holds the
//             loader FSM state encoding and helpers that derive element size,
//             per-field byte offsets/sizes and the total block size from the
//             DSIZE/LEN parameters of the instantiating module.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package kalman_param_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Field indices in memory order: x0, P0, F, B, H, Q, R.
  localparam int NUM_FIELDS = 7;
  localparam int FLD_X0     = 0;
  localparam int FLD_P0     = 1;
  localparam int FLD_F      = 2;
  localparam int FLD_B      = 3;
  localparam int FLD_H      = 4;
  localparam int FLD_Q      = 5;
  localparam int FLD_R      = 6;

  function automatic int elem_bytes(input int dsize);
    return dsize / 8;
  endfunction

  // x0 and B are vectors (LEN elements); the rest are LEN x LEN matrices.
  function automatic int field_size(input int fld, input int eb, input int len);
    if (fld == FLD_X0 || fld == FLD_B) return eb * len;
    return eb * len * len;
  endfunction

  // Fields are contiguous, so a field's offset is the sum of all earlier sizes.
  function automatic int field_off(input int fld, input int eb, input int len);
    int off;
    off = 0;
    for (int i = 0; i < fld; i++) off += field_size(i, eb, len);
    return off;
  endfunction

  function automatic int total_bytes(input int eb, input int len);
    return field_off(NUM_FIELDS, eb, len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/kalman_byte_packer.sv
`default_nettype none
// ============================================================================
// Module    : kalman_byte_packer
// Purpose   : Capture datapath of the parameter loader. Tracks issued BRAM
//             reads through an RD_LAT-deep valid pipe and writes each returned
//             byte, in arrival order, into a TOTAL-byte little-endian block.
//             The seven model fields are fixed slices of that block.
// Ports     : clk, rst        - clock, synchronous active-high reset
//             clear           - restart: empties block, counter and valid pipe
//             issue           - a read was issued this cycle
//             mem_dout        - BRAM read data
//             last_cap        - final byte of the block is captured this cycle
//             x0,P0,F,B,H,Q,R - field views of the captured block
// Revision  : 1.0 - initial release
// ============================================================================
module kalman_byte_packer
  import kalman_param_loader_pkg::*;
#(
  parameter int DSIZE  = 16,
  parameter int LEN    = 2,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      issue,
  input  logic [7:0]                mem_dout,
  output logic                      last_cap,
  output logic [DSIZE*LEN-1:0]      x0,
  output logic [DSIZE*LEN*LEN-1:0]  P0,
  output logic [DSIZE*LEN*LEN-1:0]  F,
  output logic [DSIZE*LEN-1:0]      B,
  output logic [DSIZE*LEN*LEN-1:0]  H,
  output logic [DSIZE*LEN*LEN-1:0]  Q,
  output logic [DSIZE*LEN*LEN-1:0]  R
);

  localparam int EB     = elem_bytes(DSIZE);
  localparam int TOTAL  = total_bytes(EB, LEN);
  localparam int CW     = $clog2(TOTAL + 1);
  localparam int VW     = DSIZE * LEN;
  localparam int MW     = DSIZE * LEN * LEN;
  localparam int OFF_X0 = field_off(FLD_X0, EB, LEN);
  localparam int OFF_P0 = field_off(FLD_P0, EB, LEN);
  localparam int OFF_F  = field_off(FLD_F,  EB, LEN);
  localparam int OFF_B  = field_off(FLD_B,  EB, LEN);
  localparam int OFF_H  = field_off(FLD_H,  EB, LEN);
  localparam int OFF_Q  = field_off(FLD_Q,  EB, LEN);
  localparam int OFF_R  = field_off(FLD_R,  EB, LEN);

  logic [RD_LAT-1:0]  vpipe;
  logic               cap;
  logic [CW-1:0]      cnt;
  logic [TOTAL*8-1:0] blk;

  // Stage k of the pipe is set k+1 cycles after the issue, so the last stage
  // lines up with the cycle in which the BRAM presents that read's data.
  generate
    if (RD_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
        if (rst || clear) vpipe <= '0;
        else              vpipe <= issue;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (rst || clear) vpipe <= '0;
        else              vpipe <= {vpipe[RD_LAT-2:0], issue};
      end
    end
  endgenerate

  assign cap      = vpipe[RD_LAT-1];
  assign last_cap = cap && (cnt == CW'(TOTAL - 1));

  // Reads return in issue order, so the capture count is the byte offset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      blk <= '0;
    end else if (cap) begin
      blk[{cnt, 3'b000} +: 8] <= mem_dout;
      cnt                     <= cnt + CW'(1);
    end
  end

  assign x0 = blk[8*OFF_X0 +: VW];
  assign P0 = blk[8*OFF_P0 +: MW];
  assign F  = blk[8*OFF_F  +: MW];
  assign B  = blk[8*OFF_B  +: VW];
  assign H  = blk[8*OFF_H  +: MW];
  assign Q  = blk[8*OFF_Q  +: MW];
  assign R  = blk[8*OFF_R  +: MW];

endmodule
`default_nettype wire

// File: rtl/kalman_param_loader.sv
`default_nettype none
// ============================================================================
// Module    : kalman_param_loader
// Purpose   : Loads the byte-packed Kalman model block (x0,P0,F,B,H,Q,R) from
//             a byte-wide BRAM port and presents it as packed field vectors.
//             Holds the load FSM and the BRAM address counter; the capture
//             datapath lives in kalman_byte_packer.
// Ports     : clk, rst        - core clock, synchronous active-high reset
//             start           - load request, honoured in IDLE or DONE
//             mem_addr        - BRAM byte address (16 bit)
//             mem_dout        - BRAM data, RD_LAT cycles after mem_addr
//             busy            - load in progress
//             done            - all fields valid (level)
//             x0,P0,F,B,H,Q,R - model fields, little-endian packed
// Revision  : 1.0 - initial release
// ============================================================================
module kalman_param_loader
  import kalman_param_loader_pkg::*;
#(
  parameter int DSIZE  = 16,
  parameter int LEN    = 2,
  parameter int BASE   = 2,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [15:0]               mem_addr,
  input  logic [7:0]                mem_dout,
  output logic                      busy,
  output logic                      done,
  output logic [DSIZE*LEN-1:0]      x0,
  output logic [DSIZE*LEN*LEN-1:0]  P0,
  output logic [DSIZE*LEN*LEN-1:0]  F,
  output logic [DSIZE*LEN-1:0]      B,
  output logic [DSIZE*LEN*LEN-1:0]  H,
  output logic [DSIZE*LEN*LEN-1:0]  Q,
  output logic [DSIZE*LEN*LEN-1:0]  R
);

  localparam int          EB        = elem_bytes(DSIZE);
  localparam int          TOTAL     = total_bytes(EB, LEN);
  localparam logic [15:0] BASE_ADDR = 16'(BASE);
  localparam logic [15:0] LAST_ADDR = 16'(BASE + TOTAL - 1);

  state_t state, state_n;
  logic   clear;
  logic   issue;
  logic   last_cap;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    issue   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = 1'b1;
        if (mem_addr == LAST_ADDR) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Move on the same edge the final byte is written so done rises
        // in the cycle right after the last capture.
        if (last_cap) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The final address is held through DRAIN/DONE; restart reloads BASE.
  always_ff @(posedge clk) begin
    if (rst || clear)                         mem_addr <= BASE_ADDR;
    else if (issue && mem_addr != LAST_ADDR)  mem_addr <= mem_addr + 16'd1;
  end

  assign busy = (state == ST_FETCH) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin : p_param_check
    if (!rst) begin
      assert ((BASE + TOTAL - 1 <= 65535) && (RD_LAT >= 1) && (RD_LAT <= 4))
        else $error("kalman_param_loader: block exceeds 16-bit space or RD_LAT out of range");
    end
  end

  kalman_byte_packer #(
    .DSIZE  (DSIZE),
    .LEN    (LEN),
    .RD_LAT (RD_LAT)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .issue    (issue),
    .mem_dout (mem_dout),
    .last_cap (last_cap),
    .x0       (x0),
    .P0       (P0),
    .F        (F),
    .B        (B),
    .H        (H),
    .Q        (Q),
    .R        (R)
  );

endmodule
`default_nettype wire

// File: tb/tb_kalman_param_loader.sv
`default_nettype none
// ============================================================================
// Module    : tb_kalman_param_loader
// Purpose   : Directed self-checking bench. Three loaders with RD_LAT=1,2,3
//             share clk/rst/start and one byte memory image, each behind its
//             own read-latency pipe.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_kalman_param_loader;

  localparam int BASE = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [15:0] mem_addr [3];
  logic [7:0]  mem_dout [3];
  logic        busy     [3];
  logic        done     [3];
  logic [31:0] x0 [3];
  logic [31:0] B  [3];
  logic [63:0] P0 [3];
  logic [63:0] F  [3];
  logic [63:0] H  [3];
  logic [63:0] Q  [3];
  logic [63:0] R  [3];

  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int addr_err;
  int done_at [3];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [7:0] rpipe [0:2];
    always @(posedge clk) begin
      rpipe[0] <= mem[mem_addr[i][7:0]];
      rpipe[1] <= rpipe[0];
      rpipe[2] <= rpipe[1];
    end
    assign mem_dout[i] = rpipe[i];

    kalman_param_loader #(
      .DSIZE (16), .LEN (2), .BASE (BASE), .RD_LAT (i + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mem_addr (mem_addr[i]),
      .mem_dout (mem_dout[i]),
      .busy     (busy[i]),
      .done     (done[i]),
      .x0       (x0[i]),
      .P0       (P0[i]),
      .F        (F[i]),
      .B        (B[i]),
      .H        (H[i]),
      .Q        (Q[i]),
      .R        (R[i])
    );
  end

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected field value from the memory image: byte k -> bits [8k+7:8k].
  function automatic logic [63:0] mfield(input int off, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = mem[BASE + off + k];
    return r;
  endfunction

  task automatic chk_fields(input int i);
    chk($sformatf("x0[%0d]", i), 384'(x0[i]), 384'(mfield(0, 4)));
    chk($sformatf("P0[%0d]", i), 384'(P0[i]), 384'(mfield(4, 8)));
    chk($sformatf("F[%0d]",  i), 384'(F[i]),  384'(mfield(12, 8)));
    chk($sformatf("B[%0d]",  i), 384'(B[i]),  384'(mfield(20, 4)));
    chk($sformatf("H[%0d]",  i), 384'(H[i]),  384'(mfield(24, 8)));
    chk($sformatf("Q[%0d]",  i), 384'(Q[i]),  384'(mfield(32, 8)));
    chk($sformatf("R[%0d]",  i), 384'(R[i]),  384'(mfield(40, 8)));
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
    for (int k = 0; k < 48; k++) begin
      case (mode)
        0:       mem[BASE + k] = 8'(k);
        1:       mem[BASE + k] = 8'hA5;
        default: mem[BASE + k] = 8'(8'hFF - k);
      endcase
    end
  endtask

  // start is high in cycle 0; cycle c runs from the c-th following edge.
  // Records the first cycle each instance shows done, bounded at 120 cycles.
  task automatic run_load(input int pulse_at);
    done_at  = '{-1, -1, -1};
    addr_err = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (done[i] === 1'b1 && done_at[i] < 0) done_at[i] = c;
      if (c <= 48 && mem_addr[1] !== 16'(BASE + c - 1)) addr_err++;
      if (c == 1) begin
        chk("busy_c1", 384'(busy[1]), 384'(1'b1));
        chk("done_c1", 384'(done[1]), 384'(1'b0));
        chk("x0_c1",   384'(x0[1]),   384'(0));
      end
      if (done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", 384'(mem_addr[1]), 384'(16'(BASE)));
    chk("rst_busy", 384'(busy[1]), 384'(1'b0));
    chk("rst_done", 384'(done[1]), 384'(1'b0));
    chk("rst_fields", {x0[1], P0[1], F[1], B[1], H[1], Q[1], R[1]}, 384'(0));

    // Idle: start low for 100 cycles.
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_addr", 384'(mem_addr[1]), 384'(16'(BASE)));
    chk("idle_busy", 384'(busy[1]), 384'(1'b0));
    chk("idle_done", 384'(done[1]), 384'(1'b0));
    chk("idle_fields", {x0[1], P0[1], F[1], B[1], H[1], Q[1], R[1]}, 384'(0));

    // Ramp load; a second start in cycle 20 must be ignored.
    run_load(20);
    chk("addr_seq", 384'(addr_err), 384'(0));
    chk("done_cyc_lat1", 384'(done_at[0]), 384'(50));
    chk("done_cyc_lat2", 384'(done_at[1]), 384'(51));
    chk("done_cyc_lat3", 384'(done_at[2]), 384'(52));
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_fields(i);
    chk("x0_const", 384'(x0[1]), 384'(32'h03020100));
    chk("P0_const", 384'(P0[1]), 384'(64'h0B0A090807060504));
    chk("B_const",  384'(B[1]),  384'(32'h17161514));
    chk("R_const",  384'(R[1]),  384'(64'h2F2E2D2C2B2A2928));
    chk("done_hold", 384'(done[1]), 384'(1'b1));
    chk("busy_after", 384'(busy[1]), 384'(1'b0));

    // Reset in cycle 30 of a load, then an all-A5 load.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 384'(busy[1]), 384'(1'b0));
    chk("midrst_done", 384'(done[1]), 384'(1'b0));
    chk("midrst_addr", 384'(mem_addr[1]), 384'(16'(BASE)));
    chk("midrst_fields", {x0[1], P0[1], F[1], B[1], H[1], Q[1], R[1]}, 384'(0));
    fill(1);
    run_load(-1);
    chk("a5_done_cyc", 384'(done_at[1]), 384'(51));
    for (int i = 0; i < 3; i++)
      chk($sformatf("a5_all[%0d]", i), {x0[i], P0[i], F[i], B[i], H[i], Q[i], R[i]},
          {48{8'hA5}});

    // Restart from DONE with a descending image.
    fill(2);
    run_load(-1);
    chk("desc_done_cyc", 384'(done_at[1]), 384'(51));
    chk("desc_x0", 384'(x0[1]), 384'(32'hFCFDFEFF));
    chk("desc_R",  384'(R[1]),  384'(64'hD0D1D2D3D4D5D6D7));
    for (int i = 0; i < 3; i++) chk_fields(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
